// File: rtl/dl_pkg.sv
// Shared width defaults for the dl_* execute-stage shared units.
package dl_pkg;
  localparam int DL_NUM_BITS = 32;
  localparam int DL_NUM_REQ  = 4;
endpackage

// File: rtl/dl_rr_arb.sv
// Round-robin grant with a rotating priority pointer; only the winner moves it.
module dl_rr_arb
  import dl_pkg::*;
#(
  parameter int N = DL_NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_nxt;
  logic          w_hit;

  // Scan ptr, ptr+1, ... with wrap; first asserted request wins.
  always_comb begin
    gnt    = '0;
    w_win  = '0;
    w_cand = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (!w_hit && req[w_cand]) begin
        w_hit = 1'b1;
        w_win = w_cand;
      end
    end
    if (en && !rst && w_hit) gnt[w_win] = 1'b1;
  end

  assign w_nxt = (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_ptr <= '0;
    else if (|gnt) r_ptr <= w_nxt;
  end
endmodule

// File: rtl/dl_rshift_a.sv
// Combinational arithmetic right shifter; sign is bit NUM_BITS-1.
module dl_rshift_a
  import dl_pkg::*;
#(
  parameter int NUM_BITS       = DL_NUM_BITS,
  parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0]       i_data,
  input  logic [NUM_SHIFT_BITS-1:0] i_shamt,
  output logic [NUM_BITS-1:0]       o_data
);
  assign o_data = $unsigned($signed(i_data) >>> i_shamt);
endmodule

// File: rtl/dl_rshift_arb.sv
// Arbitrated access to one shared arithmetic right shifter with a single-entry
// registered valid/ready response.
module dl_rshift_arb
  import dl_pkg::*;
#(
  parameter int NUM_BITS = DL_NUM_BITS,
  parameter int NUM_REQ  = DL_NUM_REQ,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS),
  localparam int ID_BITS        = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_val,
  output logic [NUM_REQ-1:0]                req_rdy,
  input  logic [NUM_REQ*NUM_BITS-1:0]       req_data,
  input  logic [NUM_REQ*NUM_SHIFT_BITS-1:0] req_shamt,
  output logic                              resp_val,
  input  logic                              resp_rdy,
  output logic [NUM_BITS-1:0]               resp_data,
  output logic [ID_BITS-1:0]                resp_id
);
  logic                      r_val;
  logic [NUM_BITS-1:0]       r_data;
  logic [ID_BITS-1:0]        r_id;

  logic                      w_can_accept;
  logic [NUM_REQ-1:0]        w_gnt;
  logic                      w_xfer;
  logic [NUM_BITS-1:0]       w_opd;
  logic [NUM_SHIFT_BITS-1:0] w_sh;
  logic [ID_BITS-1:0]        w_id;
  logic [NUM_BITS-1:0]       w_res;

  // Draining and reloading on the same edge keeps throughput at one per cycle.
  assign w_can_accept = !r_val || resp_rdy;

  dl_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_val),
    .en  (w_can_accept),
    .gnt (w_gnt)
  );

  // Grant is one-hot on an asserted request, so any grant is a transfer.
  assign w_xfer = |w_gnt;

  always_comb begin
    w_opd = '0;
    w_sh  = '0;
    w_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_opd = w_opd | req_data[i*NUM_BITS +: NUM_BITS];
        w_sh  = w_sh  | req_shamt[i*NUM_SHIFT_BITS +: NUM_SHIFT_BITS];
        w_id  = w_id  | ID_BITS'(i);
      end
    end
  end

  dl_rshift_a #(.NUM_BITS(NUM_BITS), .NUM_SHIFT_BITS(NUM_SHIFT_BITS)) u_shift (
    .i_data  (w_opd),
    .i_shamt (w_sh),
    .o_data  (w_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val  <= 1'b0;
      r_data <= '0;
      r_id   <= '0;
    end else if (w_xfer) begin
      r_val  <= 1'b1;
      r_data <= w_res;
      r_id   <= w_id;
    end else if (resp_rdy) begin
      r_val  <= 1'b0;
    end
  end

  assign req_rdy   = w_gnt;
  assign resp_val  = r_val;
  assign resp_data = r_data;
  assign resp_id   = r_id;
endmodule
